// File: rtl/control_red.sv
// rtl/control_red.sv - request/grant controller around an external three-cell priority network
// Define ROUND_ROBIN_EN to rotate priority past the last winner; otherwise requester 0 always leads.
module control_red #(
   parameter int MAX_CICLOS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] sol,
   input  logic [2:0] hecho,
   output logic [2:0] L,
   input  logic [2:0] Z,
   input  logic       I,
   output logic [2:0] conc,
   output logic       expiro,
   output logic       error
);

   typedef enum logic [1:0] {ESPERA, EVALUA, CONCEDE, LIBERA} state_t;

   state_t     state, state_n;
   logic [2:0] L_n, conc_n, conc_w;
   logic [1:0] ptr, ptr_n, idx, idx_n, win_idx;
   logic [3:0] cnt, cnt_n;
   logic       z_onehot;

   // Network cell k sees requester (k+p) mod 3.
   function automatic logic [2:0] rot(input logic [2:0] v, input logic [1:0] p);
      case (p)
         2'd1:    rot = {v[0], v[2], v[1]};
         2'd2:    rot = {v[1], v[0], v[2]};
         default: rot = v;
      endcase
   endfunction

   // Inverse of rot: network cell k maps back to requester (k+p) mod 3.
   function automatic logic [2:0] unrot(input logic [2:0] z, input logic [1:0] p);
      case (p)
         2'd1:    unrot = {z[1], z[0], z[2]};
         2'd2:    unrot = {z[0], z[2], z[1]};
         default: unrot = z;
      endcase
   endfunction

   assign z_onehot = (Z == 3'b001) || (Z == 3'b010) || (Z == 3'b100);
   assign conc_w   = unrot(Z, ptr);
   assign win_idx  = conc_w[2] ? 2'd2 : (conc_w[1] ? 2'd1 : 2'd0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ESPERA;
         L     <= 3'b000;
         conc  <= 3'b000;
         ptr   <= 2'd0;
         idx   <= 2'd0;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         L     <= L_n;
         conc  <= conc_n;
         ptr   <= ptr_n;
         idx   <= idx_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      L_n     = L;
      conc_n  = conc;
      ptr_n   = ptr;
      idx_n   = idx;
      cnt_n   = cnt;
      expiro  = 1'b0;
      error   = 1'b0;
      case (state)
         ESPERA: begin
            L_n    = 3'b000;
            conc_n = 3'b000;
            if (sol != 3'b000) begin
               L_n     = rot(sol, ptr);
               state_n = EVALUA;
            end
         end
         EVALUA: begin
            if (I) begin
               L_n     = 3'b000;
               state_n = ESPERA;
            end else if (z_onehot) begin
               conc_n  = conc_w;
               idx_n   = win_idx;
               cnt_n   = 4'd0;
               state_n = CONCEDE;
            end else begin
               error   = 1'b1;
               L_n     = 3'b000;
               conc_n  = 3'b000;
               state_n = ESPERA;
            end
         end
         CONCEDE: begin
            // A release in the timeout cycle wins, so expiro only fires without hecho.
            if (hecho[idx] || (cnt == 4'(MAX_CICLOS - 1))) begin
               expiro  = ~hecho[idx];
               conc_n  = 3'b000;
               L_n     = 3'b000;
               state_n = LIBERA;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         LIBERA: begin
            conc_n  = 3'b000;
            L_n     = 3'b000;
`ifdef ROUND_ROBIN_EN
            ptr_n   = (idx == 2'd2) ? 2'd0 : 2'(idx + 2'd1);
`else
            ptr_n   = 2'd0;
`endif
            state_n = ESPERA;
         end
         default: state_n = ESPERA;
      endcase
      // Pulses are suppressed while reset is held so a mid-grant reset never reports a timeout.
      if (!reset) begin
         expiro = 1'b0;
         error  = 1'b0;
      end
   end

endmodule

// File: tb/tb_control_red.sv
// tb/tb_control_red.sv - self-checking bench for control_red with a behavioural network and reference model
module tb_control_red;

   localparam int MAX = 8;
`ifdef ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk, reset, I, expiro, error, force_bad;
   logic [2:0] sol, hecho, L, Z, conc;

   control_red #(.MAX_CICLOS(MAX)) dut (
      .clk(clk), .reset(reset), .sol(sol), .hecho(hecho), .L(L),
      .Z(Z), .I(I), .conc(conc), .expiro(expiro), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] lowest(input logic [2:0] v);
      if (v[0]) return 3'b001;
      if (v[1]) return 3'b010;
      if (v[2]) return 3'b100;
      return 3'b000;
   endfunction

   function automatic bit is_onehot(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   always_comb begin
      Z = force_bad ? 3'b011 : lowest(L);
      I = force_bad ? 1'b0 : (L == 3'b000);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who holds the grant, for how long, and where priority starts.
   int         m_owner = -1, m_last = 0, m_age = 0, m_ptr = 0;
   bit         m_eval = 0, m_gap = 0, m_valid = 0;
   logic [2:0] m_L = 0, m_conc = 0;
   logic [2:0] obs_L, obs_conc;
   logic       obs_expiro, obs_error;

   task automatic cycle(input logic r, input logic [2:0] s, input logic [2:0] h, input logic b);
      logic [2:0] zm;
      logic       im, e_exp, e_err;
      @(negedge clk);
      reset = r; sol = s; hecho = h; force_bad = b;
      #2;
      obs_L = L; obs_conc = conc; obs_expiro = expiro; obs_error = error;
      zm    = b ? 3'b011 : lowest(m_L);
      im    = b ? 1'b0 : (m_L == 3'b000);
      e_exp = r && (m_owner >= 0) && !h[m_owner] && (m_age == MAX - 1);
      e_err = r && m_eval && !im && !is_onehot(zm);
      if (m_valid) begin
         check("model_L", obs_L, m_L);
         check("model_conc", obs_conc, m_conc);
         check("model_expiro", obs_expiro, e_exp);
         check("model_error", obs_error, e_err);
      end
      if (!r) begin
         m_owner = -1; m_age = 0; m_ptr = 0; m_eval = 0; m_gap = 0;
         m_L = 0; m_conc = 0; m_valid = 1;
      end else if (m_gap) begin
         m_gap = 0;
         m_ptr = RR ? (m_last + 1) % 3 : 0;
      end else if (m_owner >= 0) begin
         if (h[m_owner] || m_age == MAX - 1) begin
            m_last = m_owner; m_owner = -1; m_gap = 1; m_L = 0; m_conc = 0;
         end else m_age++;
      end else if (m_eval) begin
         m_eval = 0;
         if (!im && is_onehot(zm)) begin
            for (int k = 0; k < 3; k++)
               if (zm[k]) m_owner = (k + m_ptr) % 3;
            m_conc = 3'b001 << m_owner;
            m_age  = 0;
         end else m_L = 0;
      end else if (s != 0) begin
         for (int k = 0; k < 3; k++) m_L[k] = s[(k + m_ptr) % 3];
         m_eval = 1;
      end
   endtask

   typedef struct {
      logic       r;
      logic [2:0] s, h;
      logic       chk;
      logic [2:0] e_L, e_conc;
      logic       e_exp, e_err;
   } vec_t;

   vec_t tbl[14];
   int   n_on, n_exp, exp_at, last_on, g0, g12;

   initial begin
      reset = 0; sol = 0; hecho = 0; force_bad = 0;
      tbl[0]  = '{0, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0, 0};
      tbl[1]  = '{0, 3'b000, 3'b000, 1, 3'b000, 3'b000, 0, 0};
      tbl[2]  = '{1, 3'b101, 3'b000, 1, 3'b000, 3'b000, 0, 0};
      tbl[3]  = '{1, 3'b101, 3'b000, 1, 3'b101, 3'b000, 0, 0};
      tbl[4]  = '{1, 3'b101, 3'b000, 1, 3'b101, 3'b001, 0, 0};
      tbl[5]  = '{1, 3'b101, 3'b000, 1, 3'b101, 3'b001, 0, 0};
      tbl[6]  = '{1, 3'b101, 3'b000, 1, 3'b101, 3'b001, 0, 0};
      tbl[7]  = '{1, 3'b101, 3'b001, 1, 3'b101, 3'b001, 0, 0};
      tbl[8]  = '{1, 3'b101, 3'b000, 1, 3'b000, 3'b000, 0, 0};
      tbl[9]  = '{1, 3'b101, 3'b000, 1, 3'b000, 3'b000, 0, 0};
      tbl[10] = '{1, 3'b101, 3'b000, 1, RR ? 3'b110 : 3'b101, 3'b000, 0, 0};
      tbl[11] = '{1, 3'b101, 3'b000, 1, RR ? 3'b110 : 3'b101, RR ? 3'b100 : 3'b001, 0, 0};
      tbl[12] = '{0, 3'b101, 3'b000, 1, RR ? 3'b110 : 3'b101, RR ? 3'b100 : 3'b001, 0, 0};
      tbl[13] = '{1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 0, 0};

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].r, tbl[i].s, tbl[i].h, 1'b0);
         if (tbl[i].chk) begin
            check($sformatf("vec%0d_L", i), obs_L, tbl[i].e_L);
            check($sformatf("vec%0d_conc", i), obs_conc, tbl[i].e_conc);
            check($sformatf("vec%0d_expiro", i), obs_expiro, tbl[i].e_exp);
            check($sformatf("vec%0d_error", i), obs_error, tbl[i].e_err);
         end
      end

      // Timeout: grant held exactly MAX cycles, expiro on the last of them.
      cycle(0, 0, 0, 0);
      cycle(1, 3'b010, 0, 0);
      n_on = 0; n_exp = 0; exp_at = -1; last_on = -1;
      for (int i = 0; i < 14; i++) begin
         cycle(1, 0, 0, 0);
         if (obs_conc == 3'b010) begin n_on++; last_on = i; end
         if (obs_expiro) begin n_exp++; exp_at = i; end
      end
      check("timeout_cycles", n_on, MAX);
      check("timeout_pulses", n_exp, 1);
      check("timeout_on_last", exp_at, last_on);
      check("timeout_released", obs_conc, 3'b000);

      // Release coinciding with the timeout cycle is a normal release.
      cycle(0, 0, 0, 0);
      cycle(1, 3'b100, 0, 0);
      n_on = 0; n_exp = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1, 0, (n_on == MAX - 1) ? 3'b100 : 3'b000, 0);
         if (obs_conc == 3'b100) n_on++;
         if (obs_expiro) n_exp++;
      end
      check("simul_cycles", n_on, MAX);
      check("simul_no_expiro", n_exp, 0);

      // Illegal network answer.
      cycle(0, 0, 0, 0);
      cycle(1, 3'b001, 0, 0);
      cycle(1, 0, 0, 1);
      check("err_pulse", obs_error, 1);
      check("err_conc", obs_conc, 3'b000);
      cycle(1, 0, 0, 0);
      check("err_one_cycle", obs_error, 0);
      check("err_L", obs_L, 3'b000);
      check("err_conc_after", obs_conc, 3'b000);

      // Reset during the would-be timeout cycle: no expiro, grant dropped.
      cycle(0, 0, 0, 0);
      cycle(1, 3'b001, 0, 0);
      n_on = 0; n_exp = 0;
      for (int i = 0; i < 12; i++) begin
         cycle((n_on == MAX - 1) ? 1'b0 : 1'b1, 0, 0, 0);
         if (obs_conc != 3'b000) n_on++;
         if (obs_expiro) n_exp++;
      end
      check("rst_mid_cycles", n_on, MAX);
      check("rst_mid_no_expiro", n_exp, 0);
      check("rst_mid_conc", obs_conc, 3'b000);

      // All requesting: fixed priority always grants requester 0.
      cycle(0, 0, 0, 0);
      g0 = 0; g12 = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(1, 3'b111, 3'b111, 0);
         if (obs_conc == 3'b001) g0++;
         else if (obs_conc != 3'b000) g12++;
      end
      check("prio_req0_won", g0 > 0, 1);
      check("prio_others_won", g12 > 0, RR);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1,
               3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
               ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/control_red.md
CONTROL_RED -- requirements
Module: control_red

Interface
REQ-001 Parameter: MAX_CICLOS, 8, maximum cycles a grant is held before forced release (legal range 1..15).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 Port: sol  input  3  request vector from three requesters, bit i = requester i.
REQ-005 Port: hecho  input  3  release vector; bit i high = requester i finished with the resource.
REQ-006 Port: L  output  3  registered request vector driven onto the three-cell network (L[0] to initial cell, L[2] to final cell).
REQ-007 Port: Z  input  3  network cell outputs, combinational function of L; one-hot for the winning cell.
REQ-008 Port: I  input  1  network final-cell output; high = no cell won.
REQ-009 Port: conc  output  3  registered one-hot grant to requesters, in requester numbering.
REQ-010 Port: expiro  output  1  one-cycle pulse when a grant is force-released by timeout.
REQ-011 Port: error  output  1  one-cycle pulse when the network returns an illegal result.

Function
REQ-012 FSM states: ESPERA, EVALUA, CONCEDE, LIBERA; exactly one active per cycle.
REQ-013 ESPERA: L=0, conc=0; if sol!=0, L <= rot(sol, ptr) and go to EVALUA; else stay.
REQ-014 rot(v,p): network cell k receives requester (k+p) mod 3; unrot(Z,p) maps network cell k back to requester (k+p) mod 3.
REQ-015 EVALUA (one cycle after L driven): if I=1 go to ESPERA with L <= 0, no grant; if I=0 and Z one-hot, conc <= unrot(Z,ptr), latch winner index idx, clear hold counter, go to CONCEDE.
REQ-016 EVALUA with I=0 and Z not one-hot (zero or multiple bits): pulse error, L <= 0, conc stays 0, go to ESPERA.
REQ-017 Request-to-grant latency: conc asserted exactly 2 cycles after sol first seen nonzero in ESPERA.
REQ-018 CONCEDE: conc and L held constant; counter increments each cycle; changes on sol ignored.
REQ-019 CONCEDE exit: hecho[idx]=1 -> LIBERA; else counter = MAX_CICLOS-1 -> LIBERA with expiro pulsed that cycle; hecho on other bits ignored.
REQ-020 Simultaneous hecho[idx]=1 and timeout in same cycle: treat as normal release, expiro not pulsed.
REQ-021 LIBERA: conc <= 0, L <= 0, ptr updated per REQ-025, unconditionally to ESPERA next cycle (one idle cycle between grants).
REQ-022 ptr is 2-bit, values 0..2 only; wrap 2 -> 0.

Reset
REQ-023 reset=0 at a clock edge: state=ESPERA, L=000, conc=000, ptr=0, counter=0, expiro=0, error=0, regardless of current state.
REQ-024 Reset mid-grant drops conc on the next edge with no expiro pulse; first post-reset arbitration uses ptr=0.

Configuration
REQ-025 Macro ROUND_ROBIN_EN defined: in LIBERA ptr <= (idx+1) mod 3, rotating priority past the last winner; undefined: ptr held at 0 permanently, fixed priority (requester 0 highest via cell 0).

Verification
REQ-026 Reset low 2 cycles then sol=101 -> L=101 next cycle, conc=001 one cycle later, expiro=0.
REQ-027 Grant to requester 0, hecho=001 after 3 cycles -> conc=000 next cycle, one ESPERA cycle, with ROUND_ROBIN_EN and sol still 101 next conc=100.
REQ-028 sol=010, hecho held 0, MAX_CICLOS=8 -> conc=010 for exactly 8 cycles, expiro high on the 8th, then conc=000.
REQ-029 Model network forced Z=011, I=0 in EVALUA -> error pulse 1 cycle, conc=000, back to ESPERA.
REQ-030 Reset asserted during CONCEDE -> conc=000 and L=000 after that edge, expiro=0; without ROUND_ROBIN_EN sol=111 always grants 001.
